spmv_mem_arbiter: RTL and testbench

- Schedules the single memory-request port of the SpMV tight accelerator among NUM_REQ internal requesters: vector prefetch (requester 0) and the compute channels (1..NUM_REQ-1).
- Allocates transaction IDs from a pool of 2^TID_W.
- Records the owner of each outstanding request and routes each L2 response back to that owner.
- Sits between the accelerator control/channels and the mem_req_*/mem_resp_* ports of the accelerator interface.

---
 rtl/spmv_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_spmv_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mem_arbiter.sv
// Memory-request arbiter for the SpMV accelerator: grants the single request port among
// NUM_REQ requesters, allocates transids, and routes L2 responses back to their owners.
module spmv_mem_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TID_W   = 6,
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned PRIO0   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_val,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [TID_W-1:0]          mem_req_transid,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_resp_val,
  input  logic [TID_W-1:0]          mem_resp_transid,
  input  logic [DATA_W-1:0]         mem_resp_data,
  output logic [NUM_REQ-1:0]        rsp_val,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [TID_W:0]            inflight,
  output logic                      idle,
  output logic                      err_spurious
);

  localparam int unsigned    Pool    = 1 << TID_W;
  localparam int unsigned    OwnW    = $clog2(NUM_REQ);
  localparam logic [TID_W:0] PoolCnt = (TID_W+1)'(Pool);
  localparam logic [TID_W:0] CntOne  = (TID_W+1)'(1);

  logic                stage_full_q, stage_full_d;
  logic [TID_W-1:0]    stage_tid_q, stage_tid_d;
  logic [ADDR_W-1:0]   stage_addr_q, stage_addr_d;
  logic [OwnW-1:0]     rr_q, rr_d;
  logic [Pool-1:0]     valid_q, valid_d;
  logic [OwnW-1:0]     owner_q [Pool];
  logic [OwnW-1:0]     owner_d [Pool];
  logic [TID_W:0]      inflight_q, inflight_d;
  logic [NUM_REQ-1:0]  rsp_val_q, rsp_val_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  logic                can_load, tid_avail, found, accept, resp_hit;
  logic [OwnW-1:0]     winner;
  logic [TID_W-1:0]    free_tid;
  int                  idx;

  // Grant winner: requester 0 first when prioritised, else first valid from rr_q with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    if ((PRIO0 != 0) && req_val[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        idx = int'(rr_q) + k;
        if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
        if (!found && req_val[idx]) begin
          found  = 1'b1;
          winner = OwnW'(idx);
        end
      end
    end
  end

  // Lowest-index free transid; a tid cleared this cycle is still marked valid here.
  always_comb begin
    free_tid = '0;
    for (int t = int'(Pool) - 1; t >= 0; t--) begin
      if (!valid_q[t]) free_tid = TID_W'(t);
    end
  end

  always_comb begin
    can_load  = !stage_full_q || mem_req_rdy;
    tid_avail = inflight_q < PoolCnt;
    accept    = found && can_load && tid_avail;
    resp_hit  = mem_resp_val && valid_q[mem_resp_transid];
    req_rdy   = accept ? (NUM_REQ'(1) << winner) : '0;
  end

  always_comb begin
    stage_full_d = stage_full_q;
    stage_tid_d  = stage_tid_q;
    stage_addr_d = stage_addr_q;
    rr_d         = rr_q;
    valid_d      = valid_q;
    owner_d      = owner_q;
    inflight_d   = inflight_q;
    rsp_val_d    = '0;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q;

    if (accept) begin
      stage_full_d      = 1'b1;
      stage_tid_d       = free_tid;
      stage_addr_d      = req_addr[int'(winner)*ADDR_W +: ADDR_W];
      rr_d              = (int'(winner) == int'(NUM_REQ) - 1) ? '0 : winner + OwnW'(1);
      valid_d[free_tid] = 1'b1;
      owner_d[free_tid] = winner;
    end else if (mem_req_rdy) begin
      stage_full_d = 1'b0;
    end

    if (resp_hit) begin
      valid_d[mem_resp_transid] = 1'b0;
      rsp_val_d                 = NUM_REQ'(1) << owner_q[mem_resp_transid];
      rsp_data_d                = mem_resp_data;
    end
    if (mem_resp_val && !valid_q[mem_resp_transid]) err_d = 1'b1;

    unique case ({accept, resp_hit})
      2'b10:   inflight_d = inflight_q + CntOne;
      2'b01:   inflight_d = inflight_q - CntOne;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_full_q <= 1'b0;
      stage_tid_q  <= '0;
      stage_addr_q <= '0;
      rr_q         <= '0;
      valid_q      <= '0;
      inflight_q   <= '0;
      rsp_val_q    <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      stage_full_q <= stage_full_d;
      stage_tid_q  <= stage_tid_d;
      stage_addr_q <= stage_addr_d;
      rr_q         <= rr_d;
      valid_q      <= valid_d;
      inflight_q   <= inflight_d;
      rsp_val_q    <= rsp_val_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
    end
  end

  // Owner entries are only meaningful while valid_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

  assign mem_req_val     = stage_full_q;
  assign mem_req_transid = stage_tid_q;
  assign mem_req_addr    = stage_addr_q;
  assign rsp_val         = rsp_val_q;
  assign rsp_data        = rsp_data_q;
  assign inflight        = inflight_q;
  assign idle            = (inflight_q == '0) && !stage_full_q;
  assign err_spurious    = err_q;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Scoreboard bench for spmv_mem_arbiter: instance A is round-robin with 8 tids,
// instance B has requester-0 priority and a 4-entry tid pool.
module tb_spmv_mem_arbiter;

  typedef struct packed {
    logic [3:0]  tid;
    logic [39:0] addr;
  } req_t;

  typedef struct packed {
    logic [3:0]   val;
    logic [511:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   a_req_val, a_req_rdy, a_rsp_val;
  logic [159:0] a_req_addr;
  logic         a_mem_req_val, a_mem_req_rdy, a_mem_resp_val, a_idle, a_err;
  logic [2:0]   a_mem_req_transid, a_mem_resp_transid;
  logic [39:0]  a_mem_req_addr;
  logic [511:0] a_mem_resp_data, a_rsp_data;
  logic [3:0]   a_inflight;

  logic [3:0]   b_req_val, b_req_rdy, b_rsp_val;
  logic [159:0] b_req_addr;
  logic         b_mem_req_val, b_mem_req_rdy, b_mem_resp_val, b_idle, b_err;
  logic [1:0]   b_mem_req_transid, b_mem_resp_transid;
  logic [39:0]  b_mem_req_addr;
  logic [511:0] b_mem_resp_data, b_rsp_data;
  logic [2:0]   b_inflight;

  spmv_mem_arbiter #(
    .NUM_REQ(4), .TID_W(3), .ADDR_W(40), .DATA_W(512), .PRIO0(0)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .req_val(a_req_val), .req_addr(a_req_addr), .req_rdy(a_req_rdy),
    .mem_req_val(a_mem_req_val), .mem_req_rdy(a_mem_req_rdy),
    .mem_req_transid(a_mem_req_transid), .mem_req_addr(a_mem_req_addr),
    .mem_resp_val(a_mem_resp_val), .mem_resp_transid(a_mem_resp_transid),
    .mem_resp_data(a_mem_resp_data),
    .rsp_val(a_rsp_val), .rsp_data(a_rsp_data),
    .inflight(a_inflight), .idle(a_idle), .err_spurious(a_err)
  );

  spmv_mem_arbiter #(
    .NUM_REQ(4), .TID_W(2), .ADDR_W(40), .DATA_W(512), .PRIO0(1)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .req_val(b_req_val), .req_addr(b_req_addr), .req_rdy(b_req_rdy),
    .mem_req_val(b_mem_req_val), .mem_req_rdy(b_mem_req_rdy),
    .mem_req_transid(b_mem_req_transid), .mem_req_addr(b_mem_req_addr),
    .mem_resp_val(b_mem_resp_val), .mem_resp_transid(b_mem_resp_transid),
    .mem_resp_data(b_mem_resp_data),
    .rsp_val(b_rsp_val), .rsp_data(b_rsp_data),
    .inflight(b_inflight), .idle(b_idle), .err_spurious(b_err)
  );

  int   checks = 0;
  int   errors = 0;
  req_t qa[$];
  req_t qb[$];
  rsp_t qrsp[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] addr_a(input int r);
    return 40'h2000 + 40'(r) * 40'h100;
  endfunction

  function automatic logic [39:0] addr_b(input int r);
    return 40'h4000 + 40'(r) * 40'h10;
  endfunction

  task automatic set_addrs();
    for (int r = 0; r < 4; r++) begin
      a_req_addr[r*40 +: 40] = addr_a(r);
      b_req_addr[r*40 +: 40] = addr_b(r);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_a_idle", 64'(a_idle), 64'd1);
    check("rst_a_inflight", 64'(a_inflight), 64'd0);
    check("rst_a_mem_req_val", 64'(a_mem_req_val), 64'd0);
    check("rst_a_err", 64'(a_err), 64'd0);
    check("rst_a_rsp_val", 64'(a_rsp_val), 64'd0);
    check("rst_b_idle", 64'(b_idle), 64'd1);
  endtask

  // Monitor: requests are checked when they transfer, responses whenever a strobe is seen.
  always @(negedge clk) begin
    req_t ea;
    rsp_t er;
    if (a_mem_req_val && a_mem_req_rdy) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_req_unexpected: got tid %0h addr %0h want none",
                 a_mem_req_transid, a_mem_req_addr);
      end else begin
        ea = qa.pop_front();
        check("a_req_tid", 64'(a_mem_req_transid), 64'(ea.tid));
        check("a_req_addr", 64'(a_mem_req_addr), 64'(ea.addr));
      end
    end
    if (b_mem_req_val && b_mem_req_rdy) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_req_unexpected: got tid %0h addr %0h want none",
                 b_mem_req_transid, b_mem_req_addr);
      end else begin
        ea = qb.pop_front();
        check("b_req_tid", 64'(b_mem_req_transid), 64'(ea.tid));
        check("b_req_addr", 64'(b_mem_req_addr), 64'(ea.addr));
      end
    end
    if (a_rsp_val != 4'b0) begin
      if (qrsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_rsp_unexpected: got %b want none", a_rsp_val);
      end else begin
        er = qrsp.pop_front();
        check("a_rsp_val", 64'(a_rsp_val), 64'(er.val));
        checks++;
        if (a_rsp_data !== er.data) begin
          errors++;
          $display("FAIL a_rsp_data: got %0h want %0h", a_rsp_data[63:0], er.data[63:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] d;
    int           seq [3];
    seq = '{1, 3, 1};
    rst = 1'b1;
    a_req_val = '0; a_mem_req_rdy = 1'b1; a_mem_resp_val = 1'b0;
    a_mem_resp_transid = '0; a_mem_resp_data = '0;
    b_req_val = '0; b_mem_req_rdy = 1'b1; b_mem_resp_val = 1'b0;
    b_mem_resp_transid = '0; b_mem_resp_data = '0;
    a_req_addr = '0; b_req_addr = '0;
    set_addrs();
    do_reset();

    // Single request through to its response.
    a_req_addr[2*40 +: 40] = 40'h1000;
    a_req_val = 4'b0100;
    #1 check("t1_rdy", 64'(a_req_rdy), 64'h4);
    qa.push_back({4'd0, 40'h1000});
    tick();
    a_req_val = 4'b0;
    #1 check("t1_mem_req_val", 64'(a_mem_req_val), 64'd1);
    check("t1_inflight1", 64'(a_inflight), 64'd1);
    check("t1_busy", 64'(a_idle), 64'd0);
    d = {8{64'hABAB_ABAB_ABAB_ABAB}};
    a_mem_resp_val = 1'b1; a_mem_resp_transid = 3'd0; a_mem_resp_data = d;
    qrsp.push_back({4'b0100, d});
    tick();
    a_mem_resp_val = 1'b0;
    #1 check("t1_inflight0", 64'(a_inflight), 64'd0);
    check("t1_idle", 64'(a_idle), 64'd1);
    tick();
    check("t1_rsp_one_cycle", 64'(a_rsp_val), 64'd0);

    // Round-robin sweep, then accept and response in the same cycle.
    do_reset();
    set_addrs();
    a_req_val = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check("rr_rdy", 64'(a_req_rdy), 64'(4'b0001 << (k % 4)));
      qa.push_back({4'(k), addr_a(k % 4)});
      tick();
    end
    a_req_val = 4'b0100;
    d = {16{32'h3333_0003}};
    a_mem_resp_val = 1'b1; a_mem_resp_transid = 3'd3; a_mem_resp_data = d;
    #1 check("sim_rdy", 64'(a_req_rdy), 64'h4);
    qa.push_back({4'd5, addr_a(2)});
    qrsp.push_back({4'b1000, d});
    tick();
    a_req_val = 4'b0; a_mem_resp_val = 1'b0;
    #1 check("sim_inflight", 64'(a_inflight), 64'd5);
    tick();

    // Backpressure: stage holds for five cycles, then drains and regrants together.
    do_reset();
    set_addrs();
    a_mem_req_rdy = 1'b0;
    a_req_addr[1*40 +: 40] = 40'h30_0000_1000;
    a_req_val = 4'b0010;
    #1 check("bp_rdy0", 64'(a_req_rdy), 64'h2);
    qa.push_back({4'd0, 40'h30_0000_1000});
    tick();
    a_req_addr[1*40 +: 40] = 40'h30_0000_2000;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_val", 64'(a_mem_req_val), 64'd1);
      check("bp_tid", 64'(a_mem_req_transid), 64'd0);
      check("bp_addr", 64'(a_mem_req_addr), 64'h30_0000_1000);
      check("bp_rdy", 64'(a_req_rdy), 64'd0);
      tick();
    end
    a_mem_req_rdy = 1'b1;
    #1 check("bp_regrant", 64'(a_req_rdy), 64'h2);
    qa.push_back({4'd1, 40'h30_0000_2000});
    tick();
    a_req_val = 4'b0;
    tick();

    // Strict priority on B, then 1/3 alternation and pool exhaustion.
    do_reset();
    set_addrs();
    b_req_val = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      #1 check("pr_rdy", 64'(b_req_rdy), 64'h1);
      qb.push_back({4'(k), addr_b(0)});
      tick();
    end
    b_req_val = 4'b0;
    tick();
    do_reset();
    b_req_val = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1 check("alt_rdy", 64'(b_req_rdy), 64'(4'b0001 << seq[k]));
      qb.push_back({4'(k), addr_b(seq[k])});
      tick();
    end
    b_req_val = 4'b0100;
    #1 check("pool_last_rdy", 64'(b_req_rdy), 64'h4);
    qb.push_back({4'd3, addr_b(2)});
    tick();
    #1 check("pool_full_inflight", 64'(b_inflight), 64'd4);
    check("pool_full_rdy", 64'(b_req_rdy), 64'd0);
    tick();
    check("pool_full_rdy2", 64'(b_req_rdy), 64'd0);
    d = {8{64'h5A5A_0000_0000_0002}};
    b_mem_resp_val = 1'b1; b_mem_resp_transid = 2'd2; b_mem_resp_data = d;
    #1 check("pool_resp_cycle_rdy", 64'(b_req_rdy), 64'd0);
    tick();
    b_mem_resp_val = 1'b0;
    b_req_addr[2*40 +: 40] = 40'h4999;
    #1 check("pool_rsp_owner", 64'(b_rsp_val), 64'h2);
    check("pool_rsp_data", b_rsp_data[63:0], d[63:0]);
    check("pool_inflight3", 64'(b_inflight), 64'd3);
    check("pool_reuse_rdy", 64'(b_req_rdy), 64'h4);
    qb.push_back({4'd2, 40'h4999});
    tick();
    b_req_val = 4'b0;
    tick();

    // Spurious response, then reset with requests outstanding.
    do_reset();
    set_addrs();
    a_req_val = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1 check("sp_rdy", 64'(a_req_rdy), 64'(4'b0001 << k));
      qa.push_back({4'(k), addr_a(k)});
      tick();
    end
    a_req_val = 4'b0;
    a_mem_resp_val = 1'b1; a_mem_resp_transid = 3'd5; a_mem_resp_data = {16{32'hDEAD_BEEF}};
    tick();
    a_mem_resp_val = 1'b0;
    #1 check("sp_err", 64'(a_err), 64'd1);
    check("sp_no_rsp", 64'(a_rsp_val), 64'd0);
    check("sp_inflight", 64'(a_inflight), 64'd3);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1 check("mid_rst_inflight", 64'(a_inflight), 64'd0);
    check("mid_rst_idle", 64'(a_idle), 64'd1);
    check("mid_rst_err", 64'(a_err), 64'd0);
    a_mem_resp_val = 1'b1; a_mem_resp_transid = 3'd1;
    tick();
    a_mem_resp_val = 1'b0;
    #1 check("stale_err", 64'(a_err), 64'd1);
    check("stale_no_rsp", 64'(a_rsp_val), 64'd0);
    tick();

    check("qa_drained", 64'(qa.size()), 64'd0);
    check("qb_drained", 64'(qb.size()), 64'd0);
    check("qrsp_drained", 64'(qrsp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
